shift_unit: RTL and testbench

Iterative, parametrised shift unit with a valid/ready handshake on input and output. It generalises the fixed shift-by-two used in branch-target computation into a full shift engine. The engine supports logical-left, logical-right, arithmetic-right and (optionally) rotate-left by any amount. It sits beside the ALU in the execute path and serves multi-cycle shift instructions, trading latency for area through a configurable shift step per cycle.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_step.sv | 28 ++
 rtl/shift_unit.sv | 112 +++++++++++
 tb/tb_shift_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: op codes and FSM state encoding.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts data by 0..STEP bits according to op.
// Rotate-left is built only when SHIFT_UNIT_ROTATE_EN is defined; otherwise op 11 acts as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]            data,
  input  logic [1:0]                  op,
  input  logic [$clog2(STEP+1)-1:0]   amt,
  output logic [WIDTH-1:0]            result
);

  always_comb begin
    result = data << amt;
    case (op)
      OP_SRL:  result = data >> amt;
      // The MSB of the work register is always the captured operand's MSB, so it is a valid fill.
      OP_SRA:  result = $unsigned($signed(data) >>> amt);
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROL:  result = (data << amt) | (data >> (WIDTH - int'(amt)));
`endif
      default: result = data << amt;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Iterative shift engine with valid/ready on both sides; up to STEP bits shifted per cycle.
// Optional rotate-left is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int AW = $clog2(STEP + 1);
  localparam int CW = SHW + 1;

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // out_data is held while out_valid is high and out_ready is low.
  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  logic [1:0]       op_q;
  logic             accept;

  logic [WIDTH-1:0] step_data, step_out;
  logic [1:0]       step_op;
  logic [SHW-1:0]   rem_src, rem_nxt;
  logic [AW-1:0]    k;

  assign accept = in_valid & in_ready;

  // The first step is applied to the operand as it is captured, so a shift of up
  // to STEP bits completes on the accept edge itself.
  always_comb begin
    if (state == ST_BUSY) begin
      step_data = work;
      step_op   = op_q;
      rem_src   = rem;
    end else begin
      step_data = in_data;
      step_op   = in_op;
      rem_src   = in_shamt;
    end
    if (CW'(rem_src) >= CW'(STEP)) k = AW'(STEP);
    else                           k = AW'(rem_src);
    rem_nxt = rem_src - SHW'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (step_data),
    .op     (step_op),
    .amt    (k),
    .result (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = (rem_nxt == '0) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        if (rem_nxt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (accept)         state_nxt = (rem_nxt == '0) ? ST_DONE : ST_BUSY;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      rem  <= '0;
      op_q <= OP_SLL;
    end else begin
      if (accept || state == ST_BUSY) begin
        work <= step_out;
        rem  <= rem_nxt;
      end
      if (accept) op_q <= in_op;
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=32, STEP=4), directed cases then randomized traffic.
// Rotate expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;
  localparam int NREQ  = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the shift as plain arithmetic on the whole operand.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d, input int s, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = $unsigned($signed(d) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
      default: r = (s == 0) ? d : ((d << s) | (d >> (WIDTH - s)));
`else
      default: r = d << s;
`endif
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input int s);
    return (s == 0) ? 1 : (s + STEP - 1) / STEP;
  endfunction

  // Driver: one request with out_ready low until the result shows up; checks latency and value.
  task automatic run_directed(input string tag, input logic [WIDTH-1:0] d, input int s,
                              input logic [1:0] op, input logic [WIDTH-1:0] exp);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SHW'(s);
    in_op    = op;
    check({tag, " in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = SHW'($urandom_range(0, 31));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, ref_latency(s));
    check({tag, " data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle after pop"}, out_valid, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] opnd;
    int lat;
    int seen;
    int sent;
    int cyc;
    logic took;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);

    // Directed functional cases
    run_directed("sll 1<<2", 32'h0000_0001, 2, OP_SLL, 32'h0000_0004);
    run_directed("sra msb>>>31", 32'h8000_0000, 31, OP_SRA, 32'hFFFF_FFFF);
    run_directed("srl msb>>31", 32'h8000_0000, 31, OP_SRL, 32'h0000_0001);
`ifdef SHIFT_UNIT_ROTATE_EN
    run_directed("rol 4", 32'h8000_0001, 4, OP_ROL, 32'h0000_0018);
`else
    run_directed("rol 4", 32'h8000_0001, 4, OP_ROL, 32'h0000_0010);
`endif
    run_directed("sll 31", 32'hFFFF_FFFF, 31, OP_SLL, 32'h8000_0000);
    run_directed("sra positive 7", 32'h7000_0000, 7, OP_SRA, 32'h00E0_0000);
    for (int op = 0; op < 4; op++) begin
      opnd = $urandom;
      run_directed($sformatf("shamt0 op%0d", op), opnd, 0, 2'(op), opnd);
    end

    // Backpressure then back-to-back handover
    in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd8; in_op = OP_SLL;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("bp latency", lat, 2);
    held = out_data;
    check("bp data", held, 32'h0000_0100);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid held", out_valid, 1);
      check("bp in_ready low", in_ready, 0);
      check("bp data stable", out_data, held);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h3; in_shamt = 5'd1; in_op = OP_SLL;
    #1;
    check("handover in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("handover out_valid", out_valid, 1);
    check("handover data", out_data, 32'h0000_0006);
    tick();
    out_ready = 1'b0;
    check("handover idle", out_valid, 0);

    // Reset during the third BUSY cycle
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd20; in_op = OP_SRL;
    tick();
    in_valid = 1'b0;
    check("rst busy cycle1", busy, 1);
    tick();
    tick();
    check("rst busy cycle3", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst busy", busy, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst no result emitted", seen, 0);
    out_ready = 1'b0;

    // Randomized traffic against the scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < NREQ || exp_q.size() > 0) && cyc < 90000) begin
      if (!in_valid && sent < NREQ && $urandom_range(0, 7) != 0) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_shamt = SHW'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        check("rand result expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rand data", out_data, exp_q.pop_front());
      end
      took = in_valid && in_ready;
      if (took) begin
        exp_q.push_back(ref_model(in_data, int'(in_shamt), in_op));
        sent++;
      end
      tick();
      if (took) in_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    check("rand all sent", sent, NREQ);
    check("rand queue drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
